// File: rtl/vram_bus_arbiter.sv
// vram_bus_arbiter
//   Owns the single-port video RAM and shares it between three masters:
//   the CPU (default owner), the VGA line fetcher (hold/hold_ack, highest
//   priority, never preempted) and the blitter (req/gnt, bounded bursts).
//   Every ownership change passes through GAP_CYCLES dead cycles during
//   which no write can reach the RAM. Bursts longer than MAX_BURST are cut
//   off, and the CPU then keeps the bus for at least CPU_MIN cycles.
//
// Ports
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_cpu_addr/wdata/we       CPU request; o_cpu_ready = CPU owns the bus
//   i_vga_hold, i_vga_addr    VGA request; o_vga_hold_ack = VGA owns the bus
//   i_blt_req/addr/wdata/we   blitter request; o_blt_gnt = blitter owns the bus
//   o_mem_addr/wdata/we       RAM port, muxed combinationally from the owner
//   i_mem_rdata, o_rd_data    RAM read data, broadcast to every master
module vram_bus_arbiter #(
  parameter int AW         = 12,
  parameter int DW         = 16,
  parameter int GAP_CYCLES = 1,
  parameter int MAX_BURST  = 64,
  parameter int CPU_MIN    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_wdata,
  input  logic          i_cpu_we,
  output logic          o_cpu_ready,
  input  logic          i_vga_hold,
  output logic          o_vga_hold_ack,
  input  logic [AW-1:0] i_vga_addr,
  input  logic          i_blt_req,
  output logic          o_blt_gnt,
  input  logic [AW-1:0] i_blt_addr,
  input  logic [DW-1:0] i_blt_wdata,
  input  logic          i_blt_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic          o_mem_we,
  input  logic [DW-1:0] i_mem_rdata,
  output logic [DW-1:0] o_rd_data
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int CW = $clog2(CPU_MIN + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [CW-1:0] CPU_MIN_V  = CW'(CPU_MIN);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_CPU = 2'd0,
    S_GAP = 2'd1,
    S_VGA = 2'd2,
    S_BLT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    O_CPU = 2'd0,
    O_VGA = 2'd1,
    O_BLT = 2'd2
  } owner_t;

  state_t          r_state;
  owner_t          r_next_owner;
  logic [GW-1:0]   r_gap_cnt;
  logic [BW-1:0]   r_burst_cnt;
  logic [CW-1:0]   r_cpu_cnt;
  logic [AW-1:0]   r_last_addr;
  logic            r_cpu_ready;
  logic            r_vga_hold_ack;
  logic            r_blt_gnt;

  state_t          w_state_nxt;
  owner_t          w_owner_nxt;
  owner_t          w_target;
  logic [GW-1:0]   w_gap_nxt;
  logic [BW-1:0]   w_burst_nxt;
  logic [CW-1:0]   w_cpu_cnt_nxt;
  logic            w_blt_elig;
  logic [AW-1:0]   w_mem_addr;
  logic [DW-1:0]   w_mem_wdata;
  logic            w_mem_we;

  // cpu_cnt saturates at CPU_MIN, so "at least CPU_MIN" is an equality test.
  assign w_blt_elig = (r_cpu_cnt == CPU_MIN_V);

  // Next-state and bookkeeping for the ownership FSM.
  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_next_owner;
    w_target      = r_next_owner;
    w_gap_nxt     = r_gap_cnt;
    w_burst_nxt   = r_burst_cnt;
    w_cpu_cnt_nxt = r_cpu_cnt;
    case (r_state)
      S_CPU: begin
        if (r_cpu_cnt != CPU_MIN_V) begin
          w_cpu_cnt_nxt = r_cpu_cnt + 1'b1;
        end else begin
          w_cpu_cnt_nxt = r_cpu_cnt;
        end
        if (i_vga_hold) begin
          w_state_nxt = S_GAP;
          w_owner_nxt = O_VGA;
          w_gap_nxt   = '0;
        end else if (i_blt_req && w_blt_elig) begin
          w_state_nxt = S_GAP;
          w_owner_nxt = O_BLT;
          w_gap_nxt   = '0;
        end else begin
          w_state_nxt = S_CPU;
        end
      end
      S_GAP: begin
        // VGA may steal a gap that was heading to the blitter; the gap
        // counter keeps running so the dead time is not lengthened.
        if ((r_next_owner == O_BLT) && i_vga_hold) begin
          w_target = O_VGA;
        end else begin
          w_target = r_next_owner;
        end
        w_owner_nxt = w_target;
        if (r_gap_cnt == GAP_LAST) begin
          // A requester that gave up during the gap hands the bus back to the CPU.
          case (w_target)
            O_VGA:   w_state_nxt = i_vga_hold ? S_VGA : S_CPU;
            O_BLT:   w_state_nxt = i_blt_req ? S_BLT : S_CPU;
            default: w_state_nxt = S_CPU;
          endcase
        end else begin
          w_gap_nxt = r_gap_cnt + 1'b1;
        end
      end
      S_VGA: begin
        if (!i_vga_hold) begin
          w_state_nxt = S_GAP;
          w_gap_nxt   = '0;
          w_owner_nxt = (i_blt_req && w_blt_elig) ? O_BLT : O_CPU;
        end else begin
          w_state_nxt = S_VGA;
        end
      end
      S_BLT: begin
        w_burst_nxt = r_burst_cnt + 1'b1;
        if (i_vga_hold) begin
          w_state_nxt = S_GAP;
          w_gap_nxt   = '0;
          w_owner_nxt = O_VGA;
          w_burst_nxt = '0;
        end else if (!i_blt_req) begin
          w_state_nxt = S_GAP;
          w_gap_nxt   = '0;
          w_owner_nxt = O_CPU;
          w_burst_nxt = '0;
        end else if (r_burst_cnt == BURST_LAST) begin
          // Expired burst: the CPU must run CPU_MIN cycles before the blitter returns.
          w_state_nxt   = S_GAP;
          w_gap_nxt     = '0;
          w_owner_nxt   = O_CPU;
          w_burst_nxt   = '0;
          w_cpu_cnt_nxt = '0;
        end else begin
          w_state_nxt = S_BLT;
        end
      end
      default: begin
        w_state_nxt = S_CPU;
        w_owner_nxt = O_CPU;
      end
    endcase
  end

  // State, counters and registered grant outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state        <= S_CPU;
      r_next_owner   <= O_CPU;
      r_gap_cnt      <= '0;
      r_burst_cnt    <= '0;
      r_cpu_cnt      <= CPU_MIN_V;
      r_last_addr    <= i_cpu_addr;
      r_cpu_ready    <= 1'b1;
      r_vga_hold_ack <= 1'b0;
      r_blt_gnt      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_next_owner   <= w_owner_nxt;
      r_gap_cnt      <= w_gap_nxt;
      r_burst_cnt    <= w_burst_nxt;
      r_cpu_cnt      <= w_cpu_cnt_nxt;
      r_last_addr    <= w_mem_addr;
      r_cpu_ready    <= (w_state_nxt == S_CPU);
      r_vga_hold_ack <= (w_state_nxt == S_VGA);
      r_blt_gnt      <= (w_state_nxt == S_BLT);
    end
  end

  // RAM data-path mux; during a gap the previous owner's address is held
  // so its final read still completes.
  always_comb begin
    w_mem_addr  = r_last_addr;
    w_mem_wdata = '0;
    w_mem_we    = 1'b0;
    case (r_state)
      S_CPU: begin
        w_mem_addr  = i_cpu_addr;
        w_mem_wdata = i_cpu_wdata;
        w_mem_we    = i_cpu_we;
      end
      S_VGA: begin
        w_mem_addr  = i_vga_addr;
        w_mem_wdata = '0;
        w_mem_we    = 1'b0;
      end
      S_BLT: begin
        w_mem_addr  = i_blt_addr;
        w_mem_wdata = i_blt_wdata;
        w_mem_we    = i_blt_we;
      end
      default: begin
        w_mem_addr  = r_last_addr;
        w_mem_wdata = '0;
        w_mem_we    = 1'b0;
      end
    endcase
  end

  // Reset suppresses any write in the reset cycle itself and parks the
  // address on the CPU.
  assign o_mem_addr     = i_rst_n ? w_mem_addr : i_cpu_addr;
  assign o_mem_wdata    = w_mem_wdata;
  assign o_mem_we       = i_rst_n & w_mem_we;
  assign o_rd_data      = i_mem_rdata;
  assign o_cpu_ready    = r_cpu_ready;
  assign o_vga_hold_ack = r_vga_hold_ack;
  assign o_blt_gnt      = r_blt_gnt;

endmodule
